pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall sequencer for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
//  Merges stall requests from ID (load-use), EX (multi-cycle divider) and MEM (data SRAM wait) into the shared stall bus.
//  Owns the divider occupancy FSM and counter, and a saturating stall-cycle performance counter.
//  The stall bus is decoded by every pipeline register: stall[i]=1 holds stage i.
//  stall[i]=1 with stall[i+1]=0 injects a bubble into stage i+1.
// PARAMETERS
//  DIV_CYCLES  32  EX cycles a div/divu occupies, counted from the cycle after div_start; legal range 2..63
//  PERF_W      32  width of stall_cycles counter
// PORTS
//  clk           in   1       pipeline clock; all state updates on posedge
//  resetn        in   1       asynchronous, active-low reset
//  stallreq_id   in   1       ID load-use hazard request (combinational, same cycle)
//  div_start     in   1       div/divu in EX with operands valid (level while instr sits in EX)
//  div_cancel    in   1       squash in-flight divide (exception flush)
//  stallreq_mem  in   1       MEM data SRAM not ready
//  stall         out  6       stall bus [0]=PC .. [5]=WB, 1=Stop
//  div_busy      out  1       FSM in BUSY
//  div_done      out  1       1-cycle pulse, quotient/remainder valid in EX
//  div_cnt       out  6       remaining divide cycles
//  stall_cycles  out  PERF_W  cycles with stall!=0, saturating
// BEHAVIOUR
//  Reset:
//   - resetn low: FSM=IDLE, div_cnt=0, stall_cycles=0, immediately (async).
//   - While resetn is low: stall=6'b0, div_busy=0, div_done=0.
//   - Reset mid-divide abandons the divide with no done pulse.
//  FSM IDLE/BUSY/DONE:
//   - IDLE -> BUSY: div_start & !stallreq_mem & !div_cancel; load div_cnt=DIV_CYCLES-1.
//   - BUSY: div_cnt decrements by 1 per cycle; holds when stallreq_mem=1.
//   - BUSY -> DONE: div_cnt==0 & !stallreq_mem.
//   - DONE -> IDLE: unconditional next cycle; div_done=1 only in DONE.
//   - div_cancel in BUSY or DONE -> IDLE next cycle, div_cnt=0; cancel wins over all transitions.
//   - div_start seen in BUSY/DONE is ignored (same instruction still held in EX).
//   - In DONE, div_start is still high (instr not yet advanced): no restart that cycle. IDLE re-arms the next cycle.
//  Stall encoding (combinational from inputs + state), priority high->low:
//   1) stallreq_mem                               -> 6'b011111 (bubble into WB)
//   2) (IDLE & div_start & !div_cancel) | BUSY    -> 6'b001111 (bubble into MEM)
//   3) stallreq_id                                -> 6'b000111 (bubble into EX)
//   4) otherwise, including DONE                  -> 6'b000000
//  - div_cancel forces rule 2 false in the same cycle.
//  - A divide of N=DIV_CYCLES holds EX for exactly N+1 cycles: the start cycle plus N BUSY cycles.
//    div_done then releases EX, with no extra bubble; every extra mem-stall cycle extends this by 1.
//  - stall_cycles increments by 1 at posedge whenever stall!=0 and it is below all-ones; it saturates at 2^PERF_W-1.
//  - div_cnt width is fixed at 6 bits and is 0 in IDLE and DONE.
// TESTING
//  T1 reset: resetn=0 for 3 cycles with all requests high -> stall=0, div_busy=0, stall_cycles=0.
//     Release -> stall=6'b011111 in the first cycle.
//  T2 load-use: stallreq_id=1 for 1 cycle -> stall=6'b000111 for that cycle, 0 after; stall_cycles=1.
//  T3 divide, DIV_CYCLES=32: div_start held -> stall=6'b001111 for 33 cycles.
//     div_done=1 on cycle 34 with stall=0, then IDLE; stall_cycles=33.
//  T4 mem stall mid-divide: stallreq_mem=1 for 4 cycles when div_cnt=10 -> stall=6'b011111 and div_cnt frozen at 10.
//     Then resume; div_done arrives 4 cycles later than in T3.
//  T5 cancel: div_cancel=1 at div_cnt=5 -> next cycle IDLE, div_cnt=0, no div_done.
//     With div_start low: stall=0 in the cancel cycle and after.
//  T6 saturation (PERF_W=4): 20 stalled cycles -> stall_cycles stops at 15.
//     Reset mid-divide (resetn low at div_cnt=7) -> IDLE, div_busy=0 asynchronously.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall sequencer with divider occupancy FSM and stall perf counter
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stallreq_id,
    input  logic              div_start,
    input  logic              div_cancel,
    input  logic              stallreq_mem,
    output logic [5:0]        stall,
    output logic              div_busy,
    output logic              div_done,
    output logic [5:0]        div_cnt,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] STALL_LOAD = 6'b000111;

    state_t     state, state_next;
    logic [5:0] cnt_next;
    logic       div_hold;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            div_cnt <= 6'd0;
        end else begin
            state   <= state_next;
            div_cnt <= cnt_next;
        end
    end

    // Cancel outranks every other transition, including the DONE -> IDLE step.
    always_comb begin
        state_next = state;
        cnt_next   = div_cnt;
        case (state)
            S_IDLE: begin
                cnt_next = 6'd0;
                if (div_start && !stallreq_mem && !div_cancel) begin
                    state_next = S_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (div_cancel) begin
                    state_next = S_IDLE;
                    cnt_next   = 6'd0;
                end else if (!stallreq_mem) begin
                    if (div_cnt == 6'd0) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next = div_cnt - 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                cnt_next   = 6'd0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 6'd0;
            end
        endcase
    end

    always_comb begin
        div_busy = (state == S_BUSY);
        div_done = (state == S_DONE);
        div_hold = !div_cancel && (((state == S_IDLE) && div_start) || (state == S_BUSY));
        stall    = 6'b0;
        if (!resetn) begin
            stall = 6'b0;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (div_hold) begin
            stall = STALL_DIV;
        end else if (stallreq_id) begin
            stall = STALL_LOAD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if ((stall != 6'b0) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - self-checking bench for pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_id, div_start, div_cancel, stallreq_mem;
    logic [5:0]  stall, div_cnt, stall_s, div_cnt_s;
    logic        div_busy, div_done, div_busy_s, div_done_s;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles_s;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=idle 1=dividing 2=result cycle; elapsed counts productive divide cycles.
    int      m_phase;
    int      m_elapsed;
    longint  m_perf;
    int      m_perf4;

    logic [5:0]  last_stall, last_cnt;
    logic        last_busy, last_done;
    logic [31:0] last_perf;
    logic [3:0]  last_perf4;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_CYCLES(N), .PERF_W(32)) u_dut (
        .clk(clk), .resetn(resetn), .stallreq_id(stallreq_id), .div_start(div_start),
        .div_cancel(div_cancel), .stallreq_mem(stallreq_mem), .stall(stall),
        .div_busy(div_busy), .div_done(div_done), .div_cnt(div_cnt), .stall_cycles(stall_cycles)
    );

    pipe_stall_ctrl #(.DIV_CYCLES(N), .PERF_W(4)) u_sat (
        .clk(clk), .resetn(resetn), .stallreq_id(stallreq_id), .div_start(div_start),
        .div_cancel(div_cancel), .stallreq_mem(stallreq_mem), .stall(stall_s),
        .div_busy(div_busy_s), .div_done(div_done_s), .div_cnt(div_cnt_s), .stall_cycles(stall_cycles_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_perf    = 0;
        m_perf4   = 0;
    endtask

    function automatic logic [5:0] model_stall();
        if (!resetn)                 return 6'b000000;
        if (stallreq_mem)            return 6'b011111;
        if (!div_cancel && ((m_phase == 0 && div_start) || m_phase == 1))
                                     return 6'b001111;
        if (stallreq_id)             return 6'b000111;
        return 6'b000000;
    endfunction

    // Sample at negedge, compare against the model, then advance the model over the posedge.
    task automatic cycle();
        logic [5:0] es;
        logic [5:0] ecnt;
        @(negedge clk);
        es   = model_stall();
        ecnt = (m_phase == 1) ? 6'(N - 1 - m_elapsed) : 6'd0;
        last_stall = stall;  last_cnt  = div_cnt;  last_busy  = div_busy;
        last_done  = div_done; last_perf = stall_cycles; last_perf4 = stall_cycles_s;
        chk("stall",        64'(stall),          64'(es));
        chk("div_busy",     64'(div_busy),       64'(m_phase == 1));
        chk("div_done",     64'(div_done),       64'(m_phase == 2));
        chk("div_cnt",      64'(div_cnt),        64'(ecnt));
        chk("stall_cycles", 64'(stall_cycles),   64'(m_perf));
        chk("sat_stall",    64'(stall_s),        64'(es));
        chk("sat_busy",     64'(div_busy_s),     64'(m_phase == 1));
        chk("sat_done",     64'(div_done_s),     64'(m_phase == 2));
        chk("sat_cnt",      64'(div_cnt_s),      64'(ecnt));
        chk("sat_cycles",   64'(stall_cycles_s), 64'(m_perf4));
        if (!resetn) begin
            model_reset();
        end else begin
            if (es != 6'b0) begin
                if (m_perf < 64'hFFFF_FFFF) m_perf++;
                if (m_perf4 < 15) m_perf4++;
            end
            case (m_phase)
                0: if (div_start && !stallreq_mem && !div_cancel) begin
                       m_phase   = 1;
                       m_elapsed = 0;
                   end
                1: if (div_cancel) begin
                       m_phase = 0;
                   end else if (!stallreq_mem) begin
                       m_elapsed++;
                       if (m_elapsed == N) m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_id = 0; div_start = 0; div_cancel = 0; stallreq_mem = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        model_reset();
        cycle();
        resetn = 1;
    endtask

    initial begin
        // T1: reset with every request asserted
        resetn = 0;
        model_reset();
        stallreq_id = 1; div_start = 1; div_cancel = 1; stallreq_mem = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_stall", 64'(last_stall), 64'(6'b0));
            chk("t1_busy",  64'(last_busy),  64'(1'b0));
            chk("t1_perf",  64'(last_perf),  64'(0));
        end
        resetn = 1;
        cycle();
        chk("t1_release", 64'(last_stall), 64'(6'b011111));

        // T2: single load-use request
        do_reset();
        stallreq_id = 1;
        cycle();
        chk("t2_stall", 64'(last_stall), 64'(6'b000111));
        stallreq_id = 0;
        cycle();
        chk("t2_after", 64'(last_stall), 64'(6'b0));
        chk("t2_perf",  64'(last_perf),  64'(1));

        // T3: full divide
        do_reset();
        div_start = 1;
        for (int i = 0; i < N + 1; i++) begin
            cycle();
            chk("t3_stall", 64'(last_stall), 64'(6'b001111));
        end
        cycle();
        chk("t3_done",       64'(last_done),  64'(1'b1));
        chk("t3_done_stall", 64'(last_stall), 64'(6'b0));
        div_start = 0;
        cycle();
        chk("t3_idle", 64'(last_busy), 64'(1'b0));
        chk("t3_perf", 64'(last_perf), 64'(N + 1));

        // T4: mem stall freezes the divide at div_cnt=10
        do_reset();
        div_start = 1;
        for (int i = 0; i < 22; i++) cycle();
        stallreq_mem = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_frozen", 64'(last_cnt),   64'(10));
            chk("t4_stall",  64'(last_stall), 64'(6'b011111));
        end
        stallreq_mem = 0;
        for (int i = 0; i < 11; i++) begin
            cycle();
            chk("t4_resume", 64'(last_stall), 64'(6'b001111));
        end
        cycle();
        chk("t4_done", 64'(last_done), 64'(1'b1));
        div_start = 0;
        cycle();

        // T5: cancel at div_cnt=5
        do_reset();
        div_start = 1;
        for (int i = 0; i < 27; i++) cycle();
        div_start  = 0;
        div_cancel = 1;
        cycle();
        chk("t5_cancel_stall", 64'(last_stall), 64'(6'b0));
        chk("t5_cancel_cnt",   64'(last_cnt),   64'(5));
        div_cancel = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_busy", 64'(last_busy),  64'(1'b0));
            chk("t5_cnt",  64'(last_cnt),   64'(0));
            chk("t5_done", 64'(last_done),  64'(1'b0));
            chk("t5_stall", 64'(last_stall), 64'(6'b0));
        end

        // T6: saturation on the 4-bit counter, then asynchronous reset mid-divide
        do_reset();
        stallreq_id = 1;
        for (int i = 0; i < 20; i++) cycle();
        stallreq_id = 0;
        cycle();
        chk("t6_sat", 64'(last_perf4), 64'(15));
        chk("t6_wide", 64'(last_perf), 64'(20));
        do_reset();
        div_start = 1;
        for (int i = 0; i < 25; i++) cycle();
        chk("t6_pre_cnt", 64'(div_cnt), 64'(7));
        resetn = 0;
        #1;
        chk("t6_async_busy",  64'(div_busy), 64'(1'b0));
        chk("t6_async_cnt",   64'(div_cnt),  64'(0));
        chk("t6_async_stall", 64'(stall),    64'(6'b0));
        chk("t6_async_done",  64'(div_done), 64'(1'b0));
        model_reset();
        div_start = 0;
        cycle();
        resetn = 1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            div_start    = ($urandom_range(0, 3) != 0);
            div_cancel   = ($urandom_range(0, 15) == 0);
            stallreq_mem = ($urandom_range(0, 5) == 0);
            stallreq_id  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                resetn = 0;
                model_reset();
            end else begin
                resetn = 1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
